// File: rtl/crossbar_pkg.sv
// Shared constants and elaboration-time helpers for the round-robin crossbar.
// Holds the clog2/select-width derivation and the legal parameter ranges.
package crossbar_pkg;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 16;
  localparam int MIN_DW    = 1;
  localparam int MAX_DW    = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // A single-port index still needs one bit of select.
  function automatic int sel_width(input int n_ports);
    return (clog2(n_ports) < 1) ? 1 : clog2(n_ports);
  endfunction

  function automatic bit params_ok(input int n_cpu, input int n_mm, input int dw);
    return (n_cpu >= MIN_PORTS) && (n_cpu <= MAX_PORTS) &&
           (n_mm  >= MIN_PORTS) && (n_mm  <= MAX_PORTS) &&
           (dw    >= MIN_DW)    && (dw    <= MAX_DW);
  endfunction

endpackage

// File: rtl/crossbar_rr_nxm_rr_arb.sv
// Per-memory-port arbiter: round-robin from a rotating pointer, or fixed
// lowest-index priority. The one-hot win vector is combinational.
module rr_arb
  import crossbar_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = sel_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fixed_prio,
  input  logic [N-1:0] cand,
  output logic [N-1:0] win
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [N-1:0]  w_win;
  logic          w_found;
  int            w_idx;

  always_comb begin
    w_win     = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    w_idx     = 0;
    if (fixed_prio) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && cand[i]) begin
          w_win[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end else begin
      // Scan upward from the pointer, wrapping at N-1; pointer moves past the winner.
      for (int i = 0; i < N; i++) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= N) w_idx = w_idx - N;
        if (!w_found && cand[w_idx]) begin
          w_win[w_idx] = 1'b1;
          w_found      = 1'b1;
          w_ptr_nxt    = (w_idx == N - 1) ? '0 : PW'(w_idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_nxt;
  end

  assign win = w_win;

endmodule

// File: rtl/crossbar_rr_nxm.sv
// N_CPU x N_MM read crossbar: per-port arbiters, registered grant pulses,
// select-error pulses and per-CPU read data that holds until the next grant.
module crossbar_rr_nxm
  import crossbar_pkg::*;
#(
  parameter  int N_CPU = 4,
  parameter  int N_MM  = 4,
  parameter  int DW    = 8,
  localparam int SELW  = sel_width(N_MM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_MM*DW-1:0]    mm_data,
  input  logic [N_CPU-1:0]      req,
  input  logic [N_CPU*SELW-1:0] sel,
  input  logic                  fixed_prio,
  output logic [N_CPU*DW-1:0]   cpu_data,
  output logic [N_CPU-1:0]      gnt,
  output logic [N_CPU-1:0]      sel_err
);

  if (!params_ok(N_CPU, N_MM, DW)) begin : g_bad_params
    $error("crossbar_rr_nxm: N_CPU/N_MM must be 2..16 and DW 1..64");
  end

  logic [N_MM-1:0][N_CPU-1:0] w_cand;
  logic [N_MM-1:0][N_CPU-1:0] w_win;
  logic [N_CPU-1:0]           w_gnt;
  logic [N_CPU-1:0]           w_err;
  logic [N_CPU-1:0][DW-1:0]   w_data;

  logic [N_CPU-1:0]           r_gnt;
  logic [N_CPU-1:0]           r_sel_err;
  logic [N_CPU-1:0][DW-1:0]   r_cpu_data;

  // Out-of-range selects are compared as integers so they never alias a real port.
  always_comb begin
    w_cand = '0;
    w_err  = '0;
    for (int c = 0; c < N_CPU; c++) begin
      w_err[c] = req[c] && (int'(sel[c*SELW +: SELW]) >= N_MM);
      for (int m = 0; m < N_MM; m++) begin
        w_cand[m][c] = req[c] && (int'(sel[c*SELW +: SELW]) == m);
      end
    end
  end

  for (genvar m = 0; m < N_MM; m++) begin : g_arb
    rr_arb #(.N(N_CPU)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .fixed_prio (fixed_prio),
      .cand       (w_cand[m]),
      .win        (w_win[m])
    );
  end

  // A CPU targets one port, so at most one win bit per CPU is set: AND-OR mux.
  always_comb begin
    w_gnt  = '0;
    w_data = '0;
    for (int c = 0; c < N_CPU; c++) begin
      for (int m = 0; m < N_MM; m++) begin
        w_gnt[c]  = w_gnt[c] | w_win[m][c];
        w_data[c] = w_data[c] | ({DW{w_win[m][c]}} & mm_data[m*DW +: DW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_sel_err  <= '0;
      r_cpu_data <= '0;
    end else begin
      r_gnt     <= w_gnt;
      r_sel_err <= w_err;
      for (int c = 0; c < N_CPU; c++) begin
        if (w_gnt[c]) r_cpu_data[c] <= w_data[c];
      end
    end
  end

  assign gnt      = r_gnt;
  assign sel_err  = r_sel_err;
  assign cpu_data = r_cpu_data;

endmodule

// File: tb/tb_crossbar_rr_nxm.sv
// Bench for crossbar_rr_nxm: a 4x4 and a 4x3 instance share stimulus and are
// checked every cycle against a queue-based behavioural model.
module tb_crossbar_rr_nxm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mm_data;
  logic [3:0]  req;
  logic [7:0]  sel;
  logic        fp;

  logic [31:0] cd_a, cd_b;
  logic [3:0]  gnt_a, gnt_b, err_a, err_b;

  int tests = 0;
  int fails = 0;

  // Model state: [instance][port] pointers, [instance][cpu] data.
  int          mp[2][4];
  logic [7:0]  md[2][4];
  logic [3:0]  mg[2];
  logic [3:0]  me[2];
  logic [79:0] exp_q[$];

  always #5 clk = ~clk;

  crossbar_rr_nxm #(.N_CPU(4), .N_MM(4), .DW(8)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .mm_data    (mm_data),
    .req        (req),
    .sel        (sel),
    .fixed_prio (fp),
    .cpu_data   (cd_a),
    .gnt        (gnt_a),
    .sel_err    (err_a)
  );

  crossbar_rr_nxm #(.N_CPU(4), .N_MM(3), .DW(8)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .mm_data    (mm_data[23:0]),
    .req        (req),
    .sel        (sel),
    .fixed_prio (fp),
    .cpu_data   (cd_b),
    .gnt        (gnt_b),
    .sel_err    (err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict the outputs that follow the next rising edge from the current inputs.
  task automatic model_step();
    int nmm, w, c2;
    logic [3:0]  g, er;
    logic [79:0] e;
    for (int k = 0; k < 2; k++) begin
      nmm = (k == 0) ? 4 : 3;
      if (rst) begin
        mg[k] = '0;
        me[k] = '0;
        for (int c = 0; c < 4; c++) md[k][c] = '0;
        for (int m = 0; m < 4; m++) mp[k][m] = 0;
      end else begin
        g  = '0;
        er = '0;
        for (int c = 0; c < 4; c++)
          if (req[c] && int'(sel[c*2 +: 2]) >= nmm) er[c] = 1'b1;
        for (int m = 0; m < nmm; m++) begin
          w = -1;
          for (int j = 0; j < 4; j++) begin
            c2 = fp ? j : (mp[k][m] + j) % 4;
            if (w < 0 && req[c2] && int'(sel[c2*2 +: 2]) == m) w = c2;
          end
          if (w >= 0) begin
            g[w]     = 1'b1;
            md[k][w] = mm_data[m*8 +: 8];
            if (!fp) mp[k][m] = (w + 1) % 4;
          end
        end
        mg[k] = g;
        me[k] = er;
      end
      e[k*40 +: 4]     = mg[k];
      e[k*40 + 4 +: 4] = me[k];
      for (int c = 0; c < 4; c++) e[k*40 + 8 + c*8 +: 8] = md[k][c];
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    logic [79:0] e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("gnt_a",  {28'd0, gnt_a}, {28'd0, e[3:0]});
      chk("err_a",  {28'd0, err_a}, {28'd0, e[7:4]});
      chk("data_a", cd_a,           e[39:8]);
      chk("gnt_b",  {28'd0, gnt_b}, {28'd0, e[43:40]});
      chk("err_b",  {28'd0, err_b}, {28'd0, e[47:44]});
      chk("data_b", cd_b,           e[79:48]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    sel     = '0;
    fp      = 1'b0;
    mm_data = {8'd255, 8'd50, 8'd160, 8'd120};
    step();
    req = 4'hF;
    sel = 8'hFF;
    step();
    chk("rst_gnt",  {28'd0, gnt_a}, 32'd0);
    chk("rst_err",  {28'd0, err_b}, 32'd0);
    chk("rst_data", cd_a, 32'd0);

    // One-to-one routing
    rst = 1'b0;
    sel = 8'hE4;
    step();
    chk("s1_gnt",  {28'd0, gnt_a}, 32'hF);
    chk("s1_data", cd_a, 32'hFF32A078);

    // Full contention on port 3
    sel = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s2_gnt",  {28'd0, gnt_a}, 32'(1 << (i % 4)));
      chk("s2_data", {24'd0, cd_a[(i % 4)*8 +: 8]}, 32'd255);
    end

    // Fixed priority from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    fp  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s3_gnt",  {28'd0, gnt_a}, 32'h1);
      chk("s3_data", {8'd0, cd_a[31:8]}, 32'd0);
    end

    // Wrap-around on port 2
    fp  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0100;
    sel = 8'h20;
    step();
    chk("s4_gnt0", {28'd0, gnt_a}, 32'h4);
    req = 4'b1001;
    sel = 8'h82;
    step();
    chk("s4_gnt1",  {28'd0, gnt_a}, 32'h8);
    chk("s4_data1", {24'd0, cd_a[31:24]}, 32'd50);
    step();
    chk("s4_gnt2",  {28'd0, gnt_a}, 32'h1);
    chk("s4_data2", {24'd0, cd_a[7:0]}, 32'd50);

    // Select error on the 3-port instance
    req = 4'b0010;
    sel = 8'h0C;
    step();
    chk("s5_err_b",  {28'd0, err_b}, 32'h2);
    chk("s5_gnt_b",  {28'd0, gnt_b}, 32'h0);
    chk("s5_data_b", {24'd0, cd_b[15:8]}, 32'd0);
    chk("s5_gnt_a",  {28'd0, gnt_a}, 32'h2);
    chk("s5_err_a",  {28'd0, err_a}, 32'h0);

    // Reset in the middle of contention
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'hF;
    sel = 8'hFF;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("s6_gnt",  {28'd0, gnt_a}, 32'h0);
    chk("s6_data", cd_a, 32'd0);
    rst = 1'b0;
    step();
    chk("s6_restart", {28'd0, gnt_a}, 32'h1);

    // Random traffic with occasional mode flips and resets
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      req     = 4'($urandom_range(0, 15));
      mm_data = $urandom;
      if ($urandom_range(0, 1) == 0) sel = 8'($urandom_range(0, 255));
      else sel = {4{2'($urandom_range(0, 3))}};
      if ($urandom_range(0, 15) == 0) fp = ~fp;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crossbar_rr_nxm.md
CROSSBAR_RR_NXM -- requirements
Module: crossbar_rr_nxm

Interface
REQ-001 Parameter N_CPU, default 4: number of requesting CPU ports, range 2..16.
REQ-002 Parameter N_MM, default 4: number of memory-module ports, range 2..16.
REQ-003 Parameter DW, default 8: data width per port, range 1..64.
REQ-004 Derived constant SELW = max(1, clog2(N_MM)): width of one select field.
REQ-005 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1: reset, synchronous, active-high.
REQ-007 mm_data  input  N_MM*DW: memory-port read data, flattened; port m occupies bits [m*DW +: DW].
REQ-008 req  input  N_CPU: per-CPU access request, level-sensitive.
REQ-009 sel  input  N_CPU*SELW: per-CPU target memory port, flattened; CPU c occupies bits [c*SELW +: SELW].
REQ-010 fixed_prio  input  1: 0 = round-robin arbitration; 1 = fixed priority, where the lowest CPU index wins.
REQ-011 cpu_data  output  N_CPU*DW: per-CPU registered read data, flattened as for mm_data.
REQ-012 gnt  output  N_CPU: per-CPU one-cycle grant pulse, registered.
REQ-013 sel_err  output  N_CPU: per-CPU one-cycle pulse flagging a request whose sel is >= N_MM.

Function
REQ-014 Each memory port m SHALL have its own arbiter; candidates are CPUs with req[c]=1 and sel[c]==m in the same cycle.
REQ-015 Round-robin mode: the winner SHALL be the first candidate found scanning upward from ptr[m], wrapping from N_CPU-1 to 0.
REQ-016 Round-robin mode: on a win by CPU w, ptr[m] SHALL become (w+1) mod N_CPU; ptr[m] SHALL be unchanged when port m has no candidate.
REQ-017 Fixed-priority mode: the winner SHALL be the lowest-index candidate, and ptr[m] SHALL NOT change.
REQ-018 Latency: for a CPU c that wins port m in cycle t, gnt[c] SHALL be 1 and cpu_data[c] SHALL equal mm_data[m] as sampled in cycle t, both in cycle t+1.
REQ-019 A losing CPU SHALL get gnt[c]=0 and SHALL keep its previous cpu_data value; it is served once it keeps req asserted and wins.
REQ-020 cpu_data[c] SHALL hold its value on every cycle in which gnt[c] is not being set.
REQ-021 At most one CPU SHALL be granted per memory port per cycle; distinct ports SHALL grant concurrently, giving up to min(N_CPU, N_MM) grants per cycle.
REQ-022 A request with sel >= N_MM SHALL enter no arbiter, SHALL pulse sel_err[c] in the next cycle, and SHALL leave gnt[c] at 0.
REQ-023 A req deasserted in a cycle SHALL NOT be considered in that cycle; there is no stored pending state outside ptr.
REQ-024 A fixed_prio change SHALL take effect in the same cycle it is sampled; ptr values SHALL be retained across mode changes.
REQ-025 If every CPU holds req to the same port in round-robin mode, each CPU SHALL be granted exactly once in every N_CPU consecutive cycles (starvation-free).

Reset
REQ-026 While rst=1 at a clock edge: gnt=0, sel_err=0, cpu_data=0 and every ptr[m]=0.
REQ-027 Requests present during reset SHALL be discarded; the first arbitration SHALL use the inputs of the first cycle after rst falls.
REQ-028 Reset asserted mid-contention SHALL abort all outstanding arbitration; no grant SHALL be issued in the cycle after the reset edge.

Structure
REQ-029 Shared package crossbar_pkg SHALL hold the clog2 function, the SELW derivation and the parameter-range checks.
REQ-030 Sub-module rr_arb (parameter N, inputs clk, rst, fixed_prio, cand[N]; output one-hot win[N]; internal ptr) SHALL be instantiated N_MM times.
REQ-031 The top level SHALL contain only candidate decode, the data mux, the output registers and OR-reduction of grants per CPU.

Verification (N_CPU=4, N_MM=4, DW=8, mm_data = {255,50,160,120} for ports 3..0)
REQ-032 Scenario 1, one-to-one routing: req=1111, sel=(0,1,2,3), fixed_prio=0 -> next cycle gnt=1111, cpu_data=(120,160,50,255).
REQ-033 Scenario 2, full contention: req=1111, all sel=3, held 8 cycles -> gnt walks 0001,0010,0100,1000 and repeats; every granted cpu_data=255.
REQ-034 Scenario 3, fixed priority: as scenario 2 with fixed_prio=1 -> gnt=0001 every cycle; CPUs 1-3 keep cpu_data=0.
REQ-035 Scenario 4, wrap-around: ptr[2] at 3 after CPU2 wins, then CPUs 0 and 3 request port 2 -> CPU3 granted first, then CPU0, cpu_data=50.
REQ-036 Scenario 5, select error: N_MM=3 build, CPU1 sel=3 -> sel_err=0010 next cycle, gnt[1]=0, cpu_data[1] unchanged.
REQ-037 Scenario 6, mid-run reset: rst pulsed during scenario 2 -> gnt=0 and cpu_data=0 in the cycle after the reset edge; arbitration restarts with CPU0.
